// File: rtl/iq_demod_pkg.sv
`default_nettype none
// ============================================================================
// Module  : iq_demod_pkg
// Brief   : Width helpers and {Q, I} lane order shared by the I/Q demod + CIC.
// Rev     : 1.0
// ============================================================================
package iq_demod_pkg;

    // Lane index of each channel inside the packed output word
    localparam int I_LANE = 0;
    localparam int Q_LANE = 1;

    function automatic int prod_width(input int adc_bits, input int amp_bits);
        return adc_bits + amp_bits;
    endfunction

    function automatic int cic_width(input int prod_bits, input int order, input int decim_log2);
        return prod_bits + order * decim_log2;
    endfunction

    // LSB of the truncated output slice [W-1 : W-OUT_BITS]
    function automatic int out_lsb(input int cic_bits, input int out_bits);
        return cic_bits - out_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cic_channel.sv
`default_nettype none
// ============================================================================
// Module  : cic_channel
// Brief   : One CIC path: N valid-gated integrators, N strobe-gated combs.
// Rev     : 1.0
// ============================================================================
module cic_channel #(
    parameter int IN_W = 28,
    parameter int W    = 40,
    parameter int N    = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [IN_W-1:0] in_data,
    input  logic            dump,
    output logic            integ_valid,
    output logic            out_valid,
    output logic [W-1:0]    out_data
);

    logic [W-1:0] acc_q  [N];
    logic [W-1:0] acc_d  [N];
    logic [W-1:0] dly_q  [N];
    logic [W-1:0] dly_d  [N];
    logic [W-1:0] comb_q [N];
    logic [W-1:0] comb_d [N];
    logic [N-1:0] iv_q, iv_d;
    logic [N-1:0] cv_q, cv_d;

    always_comb begin
        acc_d  = acc_q;
        dly_d  = dly_q;
        comb_d = comb_q;
        iv_d   = '0;
        cv_d   = '0;

        iv_d[0] = in_valid;
        if (in_valid) begin
            acc_d[0] = acc_q[0] + W'($signed(in_data));
        end
        for (int k = 1; k < N; k++) begin
            iv_d[k] = iv_q[k-1];
            if (iv_q[k-1]) begin
                acc_d[k] = acc_q[k] + acc_q[k-1];
            end
        end

        // The decimation strobe rides on the last integrator's valid
        cv_d[0] = iv_q[N-1] & dump;
        if (iv_q[N-1] & dump) begin
            comb_d[0] = acc_q[N-1] - dly_q[0];
            dly_d[0]  = acc_q[N-1];
        end
        for (int k = 1; k < N; k++) begin
            cv_d[k] = cv_q[k-1];
            if (cv_q[k-1]) begin
                comb_d[k] = comb_q[k-1] - dly_q[k];
                dly_d[k]  = comb_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iv_q <= '0;
            cv_q <= '0;
            for (int k = 0; k < N; k++) begin
                acc_q[k]  <= '0;
                dly_q[k]  <= '0;
                comb_q[k] <= '0;
            end
        end else begin
            iv_q   <= iv_d;
            cv_q   <= cv_d;
            acc_q  <= acc_d;
            dly_q  <= dly_d;
            comb_q <= comb_d;
        end
    end

    assign integ_valid = iv_q[N-1];
    assign out_valid   = cv_q[N-1];
    assign out_data    = comb_q[N-1];

endmodule
`default_nettype wire

// File: rtl/iq_demod_cic.sv
`default_nettype none
// ============================================================================
// Module  : iq_demod_cic
// Brief   : ADC x NCO mixer, dual CIC decimator, AXI-Stream {Q, I} output.
// Rev     : 1.0
// ============================================================================
module iq_demod_cic
    import iq_demod_pkg::*;
#(
    parameter int ADC_BITS       = 14,
    parameter int AMPLITUDE_BITS = 14,
    parameter int CIC_ORDER      = 3,
    parameter int DECIM_LOG2     = 10,
    parameter int OUT_BITS       = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [15:0]               s_axis_tdata,
    input  logic                      s_axis_tvalid,
    input  logic [AMPLITUDE_BITS-1:0] sin_wave,
    input  logic [AMPLITUDE_BITS-1:0] cos_wave,
    output logic [2*OUT_BITS-1:0]     m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      overrun
);

    localparam int PROD_W  = prod_width(ADC_BITS, AMPLITUDE_BITS);
    localparam int W       = cic_width(PROD_W, CIC_ORDER, DECIM_LOG2);
    localparam int OUT_LSB = out_lsb(W, OUT_BITS);

    if (OUT_BITS > W) begin : g_bad_out_bits
        $error("iq_demod_cic: OUT_BITS exceeds CIC register width");
    end
    if (CIC_ORDER < 1 || CIC_ORDER > 5) begin : g_bad_order
        $error("iq_demod_cic: CIC_ORDER must be 1..5");
    end

    logic [PROD_W-1:0]     prod_i_q, prod_i_d, prod_q_q, prod_q_d;
    logic                  prod_valid_q, prod_valid_d;
    logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
    logic [2*OUT_BITS-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  overrun_q, overrun_d;

    logic                  ich_integ_valid, qch_integ_valid;
    logic                  ich_out_valid, qch_out_valid;
    logic [W-1:0]          ich_out_data, qch_out_data;
    logic                  integ_valid, dump;
    logic                  res_valid, load;
    logic [2*OUT_BITS-1:0] res_data;
    logic [ADC_BITS-1:0]   adc_x;
    logic                  unused_bits;

    assign adc_x       = s_axis_tdata[ADC_BITS-1:0];
    assign unused_bits = ^s_axis_tdata;

    always_comb begin
        prod_valid_d = s_axis_tvalid;
        prod_i_d     = prod_i_q;
        prod_q_d     = prod_q_q;
        if (s_axis_tvalid) begin
            prod_i_d = PROD_W'($signed(adc_x)) * PROD_W'($signed(cos_wave));
            prod_q_d = PROD_W'($signed(adc_x)) * PROD_W'($signed(sin_wave));
        end

        // Both channels carry identical valid pipelines; one counter serves both
        integ_valid = ich_integ_valid & qch_integ_valid;
        cnt_d       = integ_valid ? cnt_q + 1'b1 : cnt_q;
        dump        = integ_valid && (cnt_q == {DECIM_LOG2{1'b1}});

        res_valid = ich_out_valid & qch_out_valid;
        res_data  = '0;
        res_data[I_LANE*OUT_BITS +: OUT_BITS] = ich_out_data[OUT_LSB +: OUT_BITS];
        res_data[Q_LANE*OUT_BITS +: OUT_BITS] = qch_out_data[OUT_LSB +: OUT_BITS];

        load      = res_valid && (!tvalid_q || m_axis_tready);
        tvalid_d  = tvalid_q && !m_axis_tready;
        tdata_d   = tdata_q;
        overrun_d = overrun_q;
        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = res_data;
        end else if (res_valid) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_i_q     <= '0;
            prod_q_q     <= '0;
            prod_valid_q <= 1'b0;
            cnt_q        <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            prod_i_q     <= prod_i_d;
            prod_q_q     <= prod_q_d;
            prod_valid_q <= prod_valid_d;
            cnt_q        <= cnt_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            overrun_q    <= overrun_d;
        end
    end

    cic_channel #(.IN_W(PROD_W), .W(W), .N(CIC_ORDER)) u_cic_i (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (prod_valid_q),
        .in_data     (prod_i_q),
        .dump        (dump),
        .integ_valid (ich_integ_valid),
        .out_valid   (ich_out_valid),
        .out_data    (ich_out_data)
    );

    cic_channel #(.IN_W(PROD_W), .W(W), .N(CIC_ORDER)) u_cic_q (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (prod_valid_q),
        .in_data     (prod_q_q),
        .dump        (dump),
        .integ_valid (qch_integ_valid),
        .out_valid   (qch_out_valid),
        .out_data    (qch_out_data)
    );

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign overrun       = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_iq_demod_cic.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_iq_demod_cic
// Brief   : Scoreboard bench for iq_demod_cic (R=16 instance + default instance).
// Rev     : 1.0
// ============================================================================
module tb_iq_demod_cic;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] s_tdata;
    logic        s_tvalid, s_tvalid2;
    logic [13:0] sin_w, cos_w;
    logic [63:0] m_tdata, m_tdata2;
    logic        m_tvalid, m_tvalid2, m_tready, m_tready2, ovr, ovr2;

    iq_demod_cic #(
        .ADC_BITS(14), .AMPLITUDE_BITS(14), .CIC_ORDER(3), .DECIM_LOG2(4), .OUT_BITS(32)
    ) dut (
        .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .sin_wave(sin_w), .cos_wave(cos_w), .m_axis_tdata(m_tdata),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .overrun(ovr)
    );

    iq_demod_cic dut_wide (
        .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid2),
        .sin_wave(sin_w), .cos_wave(cos_w), .m_axis_tdata(m_tdata2),
        .m_axis_tvalid(m_tvalid2), .m_axis_tready(m_tready2), .overrun(ovr2)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pres_cyc = 0;
    bit          use_wide = 1'b0;
    logic [63:0] sb[$], sb2[$], frame_exp[$];
    int          out_t[$], out_t2[$], frame_pres[$];
    logic [63:0] exp1, exp2;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] pk(input longint i, input longint q);
        return {q[31:0], i[31:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) begin
            out_t.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got I=%0d Q=%0d, want no output",
                         $signed(m_tdata[31:0]), $signed(m_tdata[63:32]));
            end else begin
                exp1 = sb.pop_front();
                if (m_tdata !== exp1) begin
                    errors++;
                    $display("FAIL out_data: got I=%0d Q=%0d, want I=%0d Q=%0d",
                             $signed(m_tdata[31:0]), $signed(m_tdata[63:32]),
                             $signed(exp1[31:0]), $signed(exp1[63:32]));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && m_tvalid2 && m_tready2) begin
            out_t2.push_back(cyc);
            checks++;
            if (sb2.size() == 0) begin
                errors++;
                $display("FAIL wide_unexpected: got I=%0d Q=%0d, want no output",
                         $signed(m_tdata2[31:0]), $signed(m_tdata2[63:32]));
            end else begin
                exp2 = sb2.pop_front();
                if (m_tdata2 !== exp2) begin
                    errors++;
                    $display("FAIL wide_data: got I=%0d Q=%0d, want I=%0d Q=%0d",
                             $signed(m_tdata2[31:0]), $signed(m_tdata2[63:32]),
                             $signed(exp2[31:0]), $signed(exp2[63:32]));
                end
            end
        end
    end

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic send(input bit v, input int x, input int c, input int s);
        s_tvalid  = v && !use_wide;
        s_tvalid2 = v && use_wide;
        s_tdata   = 16'(x);
        cos_w     = 14'(c);
        sin_w     = 14'(s);
        pres_cyc  = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) send(1'b0, 0, 0, 0);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge
    task automatic do_reset();
        s_tvalid  = 1'b0;
        s_tvalid2 = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_overrun", ovr, 0);
        chk("rst_tvalid_wide", m_tvalid2, 0);
        sb.delete(); sb2.delete(); out_t.delete(); out_t2.delete(); frame_pres.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_frames(input int frames, input int len, input int x,
                              input int c, input int s, input bit gaps);
        for (int f = 0; f < frames; f++) begin
            for (int k = 0; k < len; k++) begin
                if (gaps) send(1'b0, x, c, s);
                send(1'b1, x, c, s);
            end
            frame_pres.push_back(pres_cyc);
            if (use_wide) sb2.push_back(frame_exp[f]);
            else          sb.push_back(frame_exp[f]);
        end
    endtask

    task automatic chk_frames(input string name, input int n, input int spacing);
        int t[$];
        if (use_wide) t = out_t2;
        else          t = out_t;
        chk({name, "_count"}, t.size(), n);
        chk({name, "_pending"}, use_wide ? sb2.size() : sb.size(), 0);
        if (t.size() > 0 && frame_pres.size() > 0)
            chk({name, "_latency"}, t[0] - frame_pres[0], 8);
        for (int k = 1; k < t.size(); k++)
            chk({name, "_spacing"}, t[k] - t[k-1], spacing);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; s_tvalid = 1'b0; s_tvalid2 = 1'b0; s_tdata = '0;
        sin_w = '0; cos_w = '0; m_tready = 1'b1; m_tready2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // DC settle: gain 16^3 on 8191000, truncated by 2^8
        frame_exp = '{pk(26108812, 0), pk(113138187, 0), pk(131056000, 0),
                      pk(131056000, 0), pk(131056000, 0)};
        run_frames(5, 16, 1000, 8191, 0, 1'b0);
        idle(12);
        chk_frames("dc", 5, 16);

        do_reset();
        frame_exp = '{pk(0, -26108813), pk(0, -113138188), pk(0, -131056000),
                      pk(0, -131056000), pk(0, -131056000)};
        run_frames(5, 16, -1000, 0, 8191, 1'b0);
        idle(12);
        chk_frames("qpath", 5, 16);

        do_reset();
        frame_exp = '{pk(26108812, 0), pk(113138187, 0), pk(131056000, 0),
                      pk(131056000, 0), pk(131056000, 0)};
        run_frames(5, 16, 1000, 8191, 0, 1'b1);
        idle(12);
        chk_frames("gaps", 5, 32);

        // Backpressure: frame 1 held, frame 2 dropped
        do_reset();
        m_tready = 1'b0;
        for (int n = 1; n <= 39; n++) begin
            send(1'b1, 1000, 8191, 0);
            if (n == 16) sb.push_back(pk(26108812, 0));
            if (n == 24) chk("hold_data_early", m_tdata, pk(26108812, 0));
        end
        chk("ovr_set", ovr, 1);
        chk("hold_valid", m_tvalid, 1);
        chk("hold_data_late", m_tdata, pk(26108812, 0));

        // Reset 7 samples into frame 3, with tvalid and overrun both high
        do_reset();
        m_tready = 1'b1;
        repeat (15) send(1'b1, 1000, 8191, 0);
        idle(10);
        chk("post_rst_no_early", out_t.size(), 0);
        send(1'b1, 1000, 8191, 0);
        frame_pres.push_back(pres_cyc);
        sb.push_back(pk(26108812, 0));
        idle(10);
        chk_frames("post_rst", 1, 16);

        // Handshake in the same cycle a new result arrives
        do_reset();
        m_tready = 1'b0;
        for (int n = 1; n <= 38; n++) begin
            send(1'b1, 1000, 8191, 0);
            if (n == 16) sb.push_back(pk(26108812, 0));
            if (n == 32) sb.push_back(pk(113138187, 0));
        end
        m_tready = 1'b1;
        idle(6);
        chk("same_cycle_ovr", ovr, 0);
        chk("same_cycle_count", out_t.size(), 2);
        chk("same_cycle_pending", sb.size(), 0);
        if (out_t.size() == 2) chk("same_cycle_b2b", out_t[1] - out_t[0], 1);

        // Default parameters: integrators wrap within the first three frames
        do_reset();
        use_wide = 1'b1;
        frame_exp = '{pk(179481600, 0), pk(895308800, 0), pk(1073741824, 0),
                      pk(1073741824, 0), pk(1073741824, 0)};
        run_frames(5, 1024, -8192, -8192, 0, 1'b0);
        idle(12);
        chk_frames("wrap", 5, 1024);
        chk("wrap_ovr", ovr2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
